// File: rtl/irq_timer_source_pkg.sv
// Shared register map and bit positions for the interval timer peripheral.
// Imported by the timer core and by anything that talks to its bus.
package irq_timer_pkg;

    localparam logic [2:0] ADDR_CTRL      = 3'd0;
    localparam logic [2:0] ADDR_STAT      = 3'd1;
    localparam logic [2:0] ADDR_RELOAD_LO = 3'd2;
    localparam logic [2:0] ADDR_RELOAD_HI = 3'd3;
    localparam logic [2:0] ADDR_COUNT_LO  = 3'd4;
    localparam logic [2:0] ADDR_COUNT_HI  = 3'd5;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;

    localparam int STAT_PEND = 0;
    localparam int STAT_RUN  = 1;

    // Member order keeps en at bit 0, auto at bit 1 and ie at bit 2.
    typedef struct packed {
        logic ie;
        logic auto_rl;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/irq_timer_source_if.sv
// 6502-side peripheral bus seen by the timer: chip select, write strobe,
// 3-bit offset, data in both directions and the level interrupt request.
interface irq_timer_source_if;
    logic       i_cs;
    logic       i_we;
    logic [2:0] i_addr;
    logic [7:0] i_data;
    logic [7:0] o_data;
    logic       o_irq;

    modport master (
        output i_cs, i_we, i_addr, i_data,
        input  o_data, o_irq
    );

    modport slave (
        input  i_cs, i_we, i_addr, i_data,
        output o_data, o_irq
    );
endinterface

// File: rtl/irq_timer_source_tick_prescaler.sv
// Divides clk into one-cycle ticks every PRESCALE cycles while enabled.
// Held at zero while disabled; restart realigns the phase to zero.
module tick_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!en || restart || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/irq_timer_source.sv
// Bus-mapped 16-bit down-counting interval timer with one-shot/auto-reload
// modes, a write-1-to-clear pending flag and a maskable level interrupt.
module irq_timer_source
    import irq_timer_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic              clk,
    input  logic              reset,
    irq_timer_source_if.slave bus
);

    ctrl_t       r_ctrl;
    logic        r_pend;
    logic [7:0]  r_reload_lo;
    logic [7:0]  r_reload_hi;
    logic [15:0] r_count;
    logic [7:0]  r_count_hi_shadow;

    logic        w_wr;
    logic        w_rd;
    logic        w_wr_ctrl;
    logic        w_wr_stat;
    logic        w_wr_reload_lo;
    logic        w_wr_reload_hi;
    logic        w_rd_count_lo;
    logic        w_tick;
    logic        w_terminal;
    logic [7:0]  w_stat;
    logic [7:0]  w_rdata;

    assign w_wr           = bus.i_cs & bus.i_we;
    assign w_rd           = bus.i_cs & ~bus.i_we;
    assign w_wr_ctrl      = w_wr && (bus.i_addr == ADDR_CTRL);
    assign w_wr_stat      = w_wr && (bus.i_addr == ADDR_STAT);
    assign w_wr_reload_lo = w_wr && (bus.i_addr == ADDR_RELOAD_LO);
    assign w_wr_reload_hi = w_wr && (bus.i_addr == ADDR_RELOAD_HI);
    assign w_rd_count_lo  = w_rd && (bus.i_addr == ADDR_COUNT_LO);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .en      (r_ctrl.en),
        .restart (w_wr_reload_hi),
        .tick    (w_tick)
    );

    // A RELOAD_HI write loads the counter, so a coincident tick is swallowed.
    assign w_terminal = w_tick && !w_wr_reload_hi && (r_count == 16'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl            <= '0;
            r_pend            <= 1'b0;
            r_reload_lo       <= 8'd0;
            r_reload_hi       <= 8'd0;
            r_count           <= 16'd0;
            r_count_hi_shadow <= 8'd0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= ctrl_t'(bus.i_data[2:0]);
            end else if (w_terminal && !r_ctrl.auto_rl) begin
                r_ctrl.en <= 1'b0;
            end

            if (w_terminal) begin
                r_pend <= 1'b1;
            end else if (w_wr_stat && bus.i_data[STAT_PEND]) begin
                r_pend <= 1'b0;
            end

            if (w_wr_reload_lo) begin
                r_reload_lo <= bus.i_data;
            end
            if (w_wr_reload_hi) begin
                r_reload_hi <= bus.i_data;
            end

            if (w_wr_reload_hi) begin
                r_count <= {bus.i_data, r_reload_lo};
            end else if (w_terminal) begin
                if (r_ctrl.auto_rl) begin
                    r_count <= {r_reload_hi, r_reload_lo};
                end
            end else if (w_tick) begin
                r_count <= r_count - 16'd1;
            end

            // Snapshot the high byte so a LO-then-HI read pair is coherent.
            if (w_rd_count_lo) begin
                r_count_hi_shadow <= r_count[15:8];
            end
        end
    end

    always_comb begin
        w_stat            = 8'd0;
        w_stat[STAT_PEND] = r_pend;
        w_stat[STAT_RUN]  = r_ctrl.en;
    end

    always_comb begin
        w_rdata = 8'd0;
        case (bus.i_addr)
            ADDR_CTRL:      w_rdata = {5'd0, r_ctrl};
            ADDR_STAT:      w_rdata = w_stat;
            ADDR_RELOAD_LO: w_rdata = r_reload_lo;
            ADDR_RELOAD_HI: w_rdata = r_reload_hi;
            ADDR_COUNT_LO:  w_rdata = r_count[7:0];
            ADDR_COUNT_HI:  w_rdata = r_count_hi_shadow;
            default:        w_rdata = 8'd0;
        endcase
    end

    assign bus.o_data = w_rdata;
    assign bus.o_irq  = r_pend & r_ctrl.ie;

endmodule

// File: tb/tb_irq_timer_source.sv
// Directed bench for irq_timer_source: one instance at PRESCALE=1 and one at
// PRESCALE=4 on separate buses, sharing clock and reset.
module tb_irq_timer_source;
    import irq_timer_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    irq_timer_source_if bus1();
    irq_timer_source_if bus4();

    irq_timer_source #(.PRESCALE(1)) u_dut_p1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    irq_timer_source #(.PRESCALE(4)) u_dut_p4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic cs, input logic we,
                         input logic [2:0] a, input logic [7:0] d);
        bus1.i_cs   = cs & ~sel;
        bus4.i_cs   = cs & sel;
        bus1.i_we   = we;
        bus4.i_we   = we;
        bus1.i_addr = a;
        bus4.i_addr = a;
        bus1.i_data = d;
        bus4.i_data = d;
    endtask

    function automatic logic irq(input bit sel);
        return sel ? bus4.o_irq : bus1.o_irq;
    endfunction

    task automatic bus_write(input bit sel, input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        drive(sel, 1'b1, 1'b1, a, d);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
    endtask

    task automatic bus_read(input bit sel, input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        drive(sel, 1'b1, 1'b0, a, 8'd0);
        #1;
        d = sel ? bus4.o_data : bus1.o_data;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
    endtask

    task automatic wait_irq(input bit sel, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (irq(sel)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        bit         ok;
        int         t_prev;

        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("reset_irq_p1", irq(1'b0), 1'b0);
        check("reset_irq_p4", irq(1'b1), 1'b0);
        for (int a = 0; a < 8; a++) begin
            bus_read(1'b0, 3'(a), rd);
            check($sformatf("reset_read_%0d", a), rd, 8'h00);
        end
        bus_read(1'b1, ADDR_CTRL, rd);
        check("reset_ctrl_p4", rd, 8'h00);

        // Offsets 6/7 ignore writes and do not alias CTRL
        bus_write(1'b0, 3'd6, 8'hFF);
        bus_read(1'b0, 3'd6, rd);
        check("unused_addr6", rd, 8'h00);
        bus_read(1'b0, ADDR_CTRL, rd);
        check("unused_no_alias", rd, 8'h00);

        // One-shot, PRESCALE=1, reload 4: irq rises 5 clks after CTRL write edge
        bus_write(1'b0, ADDR_RELOAD_LO, 8'h04);
        bus_write(1'b0, ADDR_RELOAD_HI, 8'h00);
        bus_write(1'b0, ADDR_CTRL, 8'h05);
        repeat (4) @(posedge clk);
        #1;
        check("oneshot_irq_clk4", irq(1'b0), 1'b0);
        @(posedge clk);
        #1;
        check("oneshot_irq_clk5", irq(1'b0), 1'b1);
        bus_read(1'b0, ADDR_STAT, rd);
        check("oneshot_stat", rd, 8'h01);
        bus_read(1'b0, ADDR_CTRL, rd);
        check("oneshot_en_cleared", rd, 8'h04);
        bus_write(1'b0, ADDR_STAT, 8'h01);
        check("oneshot_w1c_irq", irq(1'b0), 1'b0);

        // Auto mode, PRESCALE=4, reload 9: period 40 clks
        bus_write(1'b1, ADDR_RELOAD_LO, 8'h09);
        bus_write(1'b1, ADDR_RELOAD_HI, 8'h00);
        bus_write(1'b1, ADDR_CTRL, 8'h07);
        t_prev = cyc;
        for (int k = 0; k < 3; k++) begin
            wait_irq(1'b1, 100, ok);
            check($sformatf("auto_timeout_%0d", k), ok, 1'b1);
            check($sformatf("auto_period_%0d", k), cyc - t_prev, 40);
            t_prev = cyc;
            bus_write(1'b1, ADDR_STAT, 8'h01);
            check($sformatf("auto_w1c_%0d", k), irq(1'b1), 1'b0);
        end
        bus_write(1'b1, ADDR_CTRL, 8'h00);
        bus_write(1'b1, ADDR_STAT, 8'h01);

        // Masking: IE=0 keeps irq low while PEND sets; enabling IE exposes it
        bus_write(1'b0, ADDR_RELOAD_LO, 8'h03);
        bus_write(1'b0, ADDR_RELOAD_HI, 8'h00);
        bus_write(1'b0, ADDR_CTRL, 8'h03);
        repeat (6) @(posedge clk);
        bus_read(1'b0, ADDR_STAT, rd);
        check("mask_stat", rd, 8'h03);
        check("mask_irq_low", irq(1'b0), 1'b0);
        bus_write(1'b0, ADDR_CTRL, 8'h07);
        check("mask_irq_exposed", irq(1'b0), 1'b1);
        bus_write(1'b0, ADDR_CTRL, 8'h00);
        bus_write(1'b0, ADDR_STAT, 8'h01);
        check("mask_cleanup_irq", irq(1'b0), 1'b0);

        // Snapshot: HI returns byte captured at LO read, not the live value
        bus_write(1'b0, ADDR_RELOAD_LO, 8'h34);
        bus_write(1'b0, ADDR_RELOAD_HI, 8'h12);
        bus_write(1'b0, ADDR_CTRL, 8'h01);
        bus_read(1'b0, ADDR_COUNT_LO, rd);
        check("snap_count_lo", rd, 8'h34);
        repeat (300) @(posedge clk);
        bus_read(1'b0, ADDR_COUNT_HI, rd);
        check("snap_count_hi_held", rd, 8'h12);
        bus_read(1'b0, ADDR_COUNT_LO, rd);
        bus_read(1'b0, ADDR_COUNT_HI, rd);
        check("snap_count_hi_fresh", rd, 8'h11);
        bus_write(1'b0, ADDR_CTRL, 8'h00);

        // Race: W1C of PEND on the same edge as the terminal event
        bus_write(1'b0, ADDR_RELOAD_LO, 8'h02);
        bus_write(1'b0, ADDR_RELOAD_HI, 8'h00);
        bus_write(1'b0, ADDR_CTRL, 8'h05);
        repeat (2) @(posedge clk);
        bus_write(1'b0, ADDR_STAT, 8'h01);
        check("race_irq_set_wins", irq(1'b0), 1'b1);
        bus_read(1'b0, ADDR_STAT, rd);
        check("race_stat", rd, 8'h01);
        bus_write(1'b0, ADDR_STAT, 8'h01);
        check("race_w1c_after", irq(1'b0), 1'b0);

        // Reset mid-count drops irq asynchronously; timer stays idle afterwards
        bus_write(1'b0, ADDR_RELOAD_LO, 8'h00);
        bus_write(1'b0, ADDR_RELOAD_HI, 8'h00);
        bus_write(1'b0, ADDR_CTRL, 8'h07);
        wait_irq(1'b0, 10, ok);
        check("rst_irq_before", ok, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_irq", irq(1'b0), 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("rst_idle_irq", irq(1'b0), 1'b0);
        bus_read(1'b0, ADDR_CTRL, rd);
        check("rst_idle_ctrl", rd, 8'h00);
        bus_read(1'b0, ADDR_COUNT_LO, rd);
        check("rst_idle_count", rd, 8'h00);
        bus_read(1'b0, ADDR_STAT, rd);
        check("rst_idle_stat", rd, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_timer_source.md
Name: irq_timer_source

Overview:
- CPU-bus-mapped programmable interval timer that drives a level interrupt request into the interrupt controller's int_in input.
- Software arms a 16-bit reload value and enables the timer.
- On terminal count the timer sets a pending flag and asserts o_irq until the CPU clears the flag by writing 1 to it.
- Sits on the 6502 peripheral bus beside the interrupt controller.

Parameters:
- PRESCALE, 4: clk cycles per timer tick. Legal range 1..65535. PRESCALE=1 means one tick every clk.

Ports:
- clk  input  1  CPU clock.
- reset  input  1  asynchronous, active-high reset.
- i_cs  input  1  chip select, qualified per clk.
- i_we  input  1  1 = write, 0 = read, valid when i_cs=1.
- i_addr  input  3  register offset.
- i_data  input  8  write data from CPU.
- o_data  output  8  read data, combinational from i_addr.
- o_irq  output  1  level interrupt request to interrupt controller int_in.

Behaviour:
- Register map:
  - 0 CTRL (RW): bit0 EN, bit1 AUTO (auto-reload), bit2 IE (irq enable); other bits read 0.
  - 1 STAT: bit0 PEND, write-1-to-clear; bit1 RUN (=EN), read-only.
  - 2 RELOAD_LO (RW).
  - 3 RELOAD_HI (RW). A write also loads the counter with {RELOAD_HI, RELOAD_LO} and resets the prescaler.
  - 4 COUNT_LO (RO). A read (i_cs & ~i_we) latches COUNT[15:8] into a shadow register.
  - 5 COUNT_HI_SHADOW (RO): returns the shadow.
  - 6, 7: read 0, writes ignored.
- Write timing: writes take effect on the posedge of clk where i_cs & i_we.
- Reset state: all registers, counter, prescaler and shadow = 0; o_irq = 0; o_data = value of the addressed register, i.e. 0.
- o_irq = PEND & IE, registered-free combinational from flops. Clearing IE masks o_irq without clearing PEND.
- Prescaler: counts 0..PRESCALE-1 while EN=1 and emits a one-cycle tick when it wraps. Held at 0 while EN=0.
- Counter, on each tick:
  - COUNT != 0: COUNT decrements by 1.
  - COUNT == 0: terminal event. PEND set next clk. If AUTO=1, COUNT reloads from {RELOAD_HI, RELOAD_LO}; if AUTO=0, EN clears (one-shot) and COUNT stays 0.
- Timing: with PRESCALE=1 and reload N, first terminal event occurs N+1 clks after EN rises. In auto mode, period is (N+1)*PRESCALE.
- Reload 0 with AUTO=1: terminal event every PRESCALE clks.
- Simultaneous events:
  - Terminal event and W1C of PEND in the same clk: PEND ends 1 (set wins).
  - RELOAD_HI write and tick in the same clk: the load wins and the prescaler restarts.
  - CTRL write clearing EN and a terminal tick in the same clk: PEND still sets and EN ends 0.
- Writing EN=1 while already running does not disturb the counter or prescaler.
- Reset asserted mid-count: immediate return to reset state. o_irq drops asynchronously.
- Interrupt controller expectation: o_irq is a level. The ISR must W1C PEND before RTI, else o_irq stays high.

Decomposition:
- Shared package irq_timer_pkg:
  - register offset localparams (CTRL=0 .. COUNT_HI=5);
  - CTRL bit positions (EN=0, AUTO=1, IE=2);
  - STAT bit positions (PEND=0, RUN=1).
- One natural sub-module: tick_prescaler (parameter PRESCALE; inputs clk, reset, en, restart; output tick).

Test Plan:
- Reset, then read all 8 offsets -> every read returns 8'h00; o_irq=0.
- PRESCALE=1: write RELOAD_LO=8'h04, RELOAD_HI=8'h00, CTRL=8'h05 (EN|IE, one-shot) -> o_irq rises exactly 5 clks after the CTRL write edge; STAT reads 8'h01; EN reads 0.
- Auto mode: reload 8'h09, CTRL=8'h07 with PRESCALE=4 -> PEND sets every 40 clks. Writing STAT=8'h01 after each event drops o_irq the next clk. Three consecutive periods measured at 40 clks.
- Masking: CTRL=8'h03 (IE=0), run to terminal -> STAT bit0=1, o_irq=0. Then write CTRL=8'h07 -> o_irq=1 next clk.
- Snapshot: reload 16'h1234, EN=1, PRESCALE=1:
  - read COUNT_LO, then wait 300 clks, read COUNT_HI -> HI equals the high byte captured at the LO read (8'h12), not the live value.
  - Race: terminal event on the same clk as STAT W1C -> PEND stays 1.
- Reset mid-count: assert reset asynchronously between clk edges while o_irq=1 -> o_irq=0 immediately. After deassert, the counter stays idle until re-armed.
